dv_data_bus_arb: RTL and testbench
==================================

// Module: dv_data_bus_arb
// PURPOSE
//  Two-master OBI-style data-bus arbiter for the CHERIoT DV bench. Shares one data-memory-model port
//  (33-bit cap-aware data) between the core data port (m0) and a bench background traffic master (m1).
//  Tracks outstanding transactions in an ID FIFO so that each rvalid/rdata/err returns to its issuer.
// PARAMETERS
//  DataWidth   33  bus data width (32 data + cap tag bit)
//  AddrWidth   32  address width
//  MaxOutstd   4   max in-flight granted transactions (ID FIFO depth, power of 2, >=2)
// PORTS
//  clk_i          in   1    clock
//  rst_ni         in   1    reset, asynchronous, active-high
//  m0_req_i       in   1    core request
//  m0_we_i        in   1    core write enable
//  m0_be_i        in   4    core byte enables
//  m0_is_cap_i    in   1    core capability access
//  m0_addr_i      in   AW   core address
//  m0_wdata_i     in   DW   core write data
//  m0_gnt_o       out  1    core grant
//  m0_rvalid_o    out  1    core response valid
//  m0_rdata_o     out  DW   core read data
//  m0_err_o       out  1    core response error
//  m1_*           -    -    background master, same set/widths as m0_*
//  s_req_o        out  1    request to data memory model
//  s_we_o/s_be_o/s_is_cap_o/s_addr_o/s_wdata_o  out  muxed request fields
//  s_gnt_i        in   1    memory grant
//  s_rvalid_i     in   1    memory response valid
//  s_rdata_i      in   DW   memory read data
//  s_err_i        in   1    memory response error
//  outstd_o       out  3    in-flight count ($clog2(MaxOutstd)+1 bits)
//  proto_err_o    out  1    sticky: rvalid received with empty ID FIFO
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; rr_last=m1 (m0 wins the first tie); FIFO empty; proto_err_o=0.
//  - FSM: IDLE, LOCK0, LOCK1. In IDLE with FIFO not full, pick a requester: sole requester wins;
//    on both, the master != rr_last wins. Selection is combinational; s_req_o asserts same cycle.
//  - If s_gnt_i=0 in the selection cycle, go to LOCKn: the mux holds master n until s_gnt_i=1
//    (masters hold req/fields stable until gnt). On grant, return to IDLE.
//  - m<n>_gnt_o = s_gnt_i & s_req_o & (sel==n); zero-cycle pass-through, no added latency.
//  - On handshake (s_req_o & s_gnt_i): push sel ID to FIFO; rr_last<=sel.
//  - Back-to-back: a handshake cycle can be followed by a new selection next cycle (1 txn/cycle max).
//  - Full: count==MaxOutstd -> s_req_o=0 and no grant, even if a pop occurs the same cycle.
//    LOCK state is held while full.
//  - Response: s_rvalid_i routes rdata/err to the master at FIFO head; pop same cycle. Other
//    master's rvalid=0 and its rdata=0. Same-cycle push+pop leaves count unchanged.
//  - s_rvalid_i with empty FIFO: drop, set proto_err_o (sticky until reset), count stays 0.
//  - Responses return in order; no reordering between masters.
//  - Reset mid-operation: FIFO/LOCK cleared immediately; late rvalids after reset raise proto_err_o.
//  - outstd_o = FIFO occupancy, 0..MaxOutstd; wraps of FIFO pointers are mod MaxOutstd.
// TESTING
//  1 m0 single read, s_gnt_i same cycle, rvalid 2 cycles later -> m0_gnt_o cycle 0, m0_rvalid_o
//    cycle 2 with rdata=33'h1_DEADBEEF, m1 outputs all 0, outstd_o 0->1->0.
//  2 m0,m1 both req continuously, gnt=1 every cycle -> grants alternate m0,m1,m0,m1; responses
//    routed in issue order.
//  3 m1 req with s_gnt_i low 3 cycles, m0 requests in cycle 1 -> FSM LOCK1, s_addr_o stays m1's
//    address, m1 granted cycle 3, m0 granted cycle 4.
//  4 MaxOutstd=4, 5 back-to-back m0 reqs, no rvalid -> 4 grants, outstd_o=4, 5th blocked; rvalid with
//    simultaneous pending req -> still no grant that cycle, grant next cycle.
//  5 s_rvalid_i pulse with FIFO empty -> proto_err_o=1 and stays 1; rst_ni=1 clears it.
//  6 s_err_i=1 on m1 response -> m1_err_o=1 with m1_rvalid_o; m0_err_o=0.

Source files
------------

// File: rtl/dv_data_bus_arb.sv
// Two-master OBI-style data-bus arbiter. m0 is the core data port and m1 is a background master.
// An ID FIFO records the issuer of each granted transaction so that every response returns to it.
module dv_data_bus_arb #(
    parameter  int unsigned DataWidth = 33,
    parameter  int unsigned AddrWidth = 32,
    parameter  int unsigned MaxOutstd = 4,
    localparam int unsigned PtrW      = $clog2(MaxOutstd),
    localparam int unsigned CntW      = PtrW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 m0_req_i,
    input  logic                 m0_we_i,
    input  logic [3:0]           m0_be_i,
    input  logic                 m0_is_cap_i,
    input  logic [AddrWidth-1:0] m0_addr_i,
    input  logic [DataWidth-1:0] m0_wdata_i,
    output logic                 m0_gnt_o,
    output logic                 m0_rvalid_o,
    output logic [DataWidth-1:0] m0_rdata_o,
    output logic                 m0_err_o,

    input  logic                 m1_req_i,
    input  logic                 m1_we_i,
    input  logic [3:0]           m1_be_i,
    input  logic                 m1_is_cap_i,
    input  logic [AddrWidth-1:0] m1_addr_i,
    input  logic [DataWidth-1:0] m1_wdata_i,
    output logic                 m1_gnt_o,
    output logic                 m1_rvalid_o,
    output logic [DataWidth-1:0] m1_rdata_o,
    output logic                 m1_err_o,

    output logic                 s_req_o,
    output logic                 s_we_o,
    output logic [3:0]           s_be_o,
    output logic                 s_is_cap_o,
    output logic [AddrWidth-1:0] s_addr_o,
    output logic [DataWidth-1:0] s_wdata_o,
    input  logic                 s_gnt_i,
    input  logic                 s_rvalid_i,
    input  logic [DataWidth-1:0] s_rdata_i,
    input  logic                 s_err_i,

    output logic [CntW-1:0]      outstd_o,
    output logic                 proto_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_e;

    state_e          state_q, state_d;
    logic            rrLast_q;
    logic            ids_q [MaxOutstd];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            protoErr_q;

    logic sel, reqValid, full, empty, push, pop, headId;

    // A locked master keeps the mux until its request is accepted; otherwise round-robin on ties.
    always_comb begin
        sel      = 1'b0;
        reqValid = 1'b0;
        unique case (state_q)
            LOCK0: begin
                sel      = 1'b0;
                reqValid = m0_req_i;
            end
            LOCK1: begin
                sel      = 1'b1;
                reqValid = m1_req_i;
            end
            default: begin
                reqValid = m0_req_i | m1_req_i;
                if (m0_req_i && m1_req_i) begin
                    sel = ~rrLast_q;
                end else begin
                    sel = m1_req_i;
                end
            end
        endcase
    end

    assign full    = (count_q == CntW'(MaxOutstd));
    assign empty   = (count_q == '0);
    assign s_req_o = reqValid & ~full;
    assign push    = s_req_o & s_gnt_i;
    assign pop     = s_rvalid_i & ~empty;
    assign headId  = ids_q[rptr_q];

    assign s_we_o     = s_req_o & (sel ? m1_we_i : m0_we_i);
    assign s_be_o     = s_req_o ? (sel ? m1_be_i : m0_be_i) : '0;
    assign s_is_cap_o = s_req_o & (sel ? m1_is_cap_i : m0_is_cap_i);
    assign s_addr_o   = s_req_o ? (sel ? m1_addr_i : m0_addr_i) : '0;
    assign s_wdata_o  = s_req_o ? (sel ? m1_wdata_i : m0_wdata_i) : '0;

    assign m0_gnt_o    = push & ~sel;
    assign m1_gnt_o    = push & sel;
    assign m0_rvalid_o = pop & ~headId;
    assign m1_rvalid_o = pop & headId;
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
    assign m0_err_o    = m0_rvalid_o & s_err_i;
    assign m1_err_o    = m1_rvalid_o & s_err_i;

    assign outstd_o    = count_q;
    assign proto_err_o = protoErr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOCK0, LOCK1: begin
                if (push) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (s_req_o && !s_gnt_i) begin
                    state_d = sel ? LOCK1 : LOCK0;
                end
            end
        endcase
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    // rrLast resets to m1 so that m0 wins the first tie after reset.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q    <= IDLE;
            rrLast_q   <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            protoErr_q <= 1'b0;
            for (int i = 0; i < int'(MaxOutstd); i++) begin
                ids_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                ids_q[wptr_q] <= sel;
                wptr_q        <= wptr_q + PtrW'(1);
                rrLast_q      <= sel;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (s_rvalid_i && empty) begin
                protoErr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dv_data_bus_arb.sv
// Directed bench for dv_data_bus_arb: inputs change on the falling edge and outputs are
// compared 1 ns later against hand-computed values.
module tb_dv_data_bus_arb;

    localparam int DW = 33;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          m0_req_i, m0_we_i, m0_is_cap_i;
    logic [3:0]    m0_be_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_wdata_i;
    logic          m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [DW-1:0] m0_rdata_o;
    logic          m1_req_i, m1_we_i, m1_is_cap_i;
    logic [3:0]    m1_be_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_wdata_i;
    logic          m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [DW-1:0] m1_rdata_o;
    logic          s_req_o, s_we_o, s_is_cap_o;
    logic [3:0]    s_be_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wdata_o;
    logic          s_gnt_i, s_rvalid_i, s_err_i;
    logic [DW-1:0] s_rdata_i;
    logic [2:0]    outstd_o;
    logic          proto_err_o;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk_i = ~clk_i;

    dv_data_bus_arb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_is_cap_i(m0_is_cap_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_is_cap_i(m1_is_cap_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_is_cap_o(s_is_cap_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .outstd_o(outstd_o), .proto_err_o(proto_err_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: drive on the falling edge, settle 1 ns before any checks.
    task automatic applyStimulus(input logic r0, input logic r1, input logic gnt,
                                 input logic rv, input logic [DW-1:0] rd, input logic er);
        @(negedge clk_i);
        m0_req_i   = r0;
        m1_req_i   = r1;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rd;
        s_err_i    = er;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        @(negedge clk_i);
        rst_ni = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b1;
        m0_we_i     = 1'b0;  m0_be_i = 4'hF;  m0_is_cap_i = 1'b0;
        m0_addr_i   = 32'h0000_1000;  m0_wdata_i = 33'h0_1111_1111;
        m1_we_i     = 1'b1;  m1_be_i = 4'h3;  m1_is_cap_i = 1'b1;
        m1_addr_i   = 32'h0000_2000;  m1_wdata_i = 33'h1_2222_2222;
        m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0; s_err_i = 0;

        // Reset state
        doReset();
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("rst_outstd", outstd_o, 0);
        checkOutput("rst_proto", proto_err_o, 0);
        checkOutput("rst_sreq", s_req_o, 0);
        checkOutput("rst_gnt", {m0_gnt_o, m1_gnt_o}, 0);

        // Single m0 read with response two cycles after the grant
        applyStimulus(1, 0, 1, 0, '0, 0);
        checkOutput("t1_m0gnt", m0_gnt_o, 1);
        checkOutput("t1_m1gnt", m1_gnt_o, 0);
        checkOutput("t1_addr", s_addr_o, 32'h0000_1000);
        checkOutput("t1_fields", {s_we_o, s_be_o, s_is_cap_o}, {1'b0, 4'hF, 1'b0});
        checkOutput("t1_outstd0", outstd_o, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t1_outstd1", outstd_o, 1);
        applyStimulus(0, 0, 0, 1, 33'h1_DEADBEEF, 0);
        checkOutput("t1_m0rv", m0_rvalid_o, 1);
        checkOutput("t1_m0rd", m0_rdata_o, 33'h1_DEADBEEF);
        checkOutput("t1_m1out", {m1_rvalid_o, m1_err_o, m1_rdata_o}, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t1_outstd2", outstd_o, 0);

        // Both masters contend with grant every cycle: m0, m1, m0, m1
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 0, '0, 0);
            checkOutput($sformatf("t2_gnt%0d", i), {m0_gnt_o, m1_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
            checkOutput($sformatf("t2_addr%0d", i), s_addr_o,
                        (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, DW'(33'h100 + i), 0);
            if (i == 0) checkOutput("t2_outstd4", outstd_o, 4);
            checkOutput($sformatf("t2_rv%0d", i), {m0_rvalid_o, m1_rvalid_o},
                        (i % 2 == 0) ? 2'b10 : 2'b01);
            checkOutput($sformatf("t2_rd%0d", i), (i % 2 == 0) ? m0_rdata_o : m1_rdata_o, 33'h100 + i);
        end
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t2_drained", outstd_o, 0);

        // m1 locks the mux while the memory stalls; m0 arrives mid-stall
        doReset();
        applyStimulus(0, 1, 0, 0, '0, 0);
        checkOutput("t3_c0_addr", s_addr_o, 32'h0000_2000);
        checkOutput("t3_c0_gnt", {m0_gnt_o, m1_gnt_o}, 0);
        applyStimulus(1, 1, 0, 0, '0, 0);
        checkOutput("t3_c1_addr", s_addr_o, 32'h0000_2000);
        checkOutput("t3_c1_wdata", s_wdata_o, 33'h1_2222_2222);
        applyStimulus(1, 1, 0, 0, '0, 0);
        checkOutput("t3_c2_addr", s_addr_o, 32'h0000_2000);
        applyStimulus(1, 1, 1, 0, '0, 0);
        checkOutput("t3_c3_gnt", {m0_gnt_o, m1_gnt_o}, 2'b01);
        applyStimulus(1, 0, 1, 0, '0, 0);
        checkOutput("t3_c4_gnt", {m0_gnt_o, m1_gnt_o}, 2'b10);
        checkOutput("t3_c4_addr", s_addr_o, 32'h0000_1000);
        applyStimulus(0, 0, 0, 1, 33'h0_0000_00AA, 0);
        checkOutput("t3_outstd", outstd_o, 2);
        checkOutput("t3_rv_m1", {m0_rvalid_o, m1_rvalid_o}, 2'b01);
        applyStimulus(0, 0, 0, 1, 33'h0_0000_00BB, 0);
        checkOutput("t3_rv_m0", {m0_rvalid_o, m1_rvalid_o}, 2'b10);
        checkOutput("t3_rd_m0", m0_rdata_o, 33'h0_0000_00BB);

        // FIFO full blocks a fifth request even when a pop happens the same cycle
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 0, '0, 0);
            checkOutput($sformatf("t4_gnt%0d", i), m0_gnt_o, 1);
        end
        applyStimulus(1, 0, 1, 0, '0, 0);
        checkOutput("t4_full_outstd", outstd_o, 4);
        checkOutput("t4_full_gnt", m0_gnt_o, 0);
        checkOutput("t4_full_sreq", s_req_o, 0);
        applyStimulus(1, 0, 1, 1, 33'h5, 0);
        checkOutput("t4_pop_gnt", m0_gnt_o, 0);
        checkOutput("t4_pop_rv", m0_rvalid_o, 1);
        applyStimulus(1, 0, 1, 0, '0, 0);
        checkOutput("t4_after_outstd", outstd_o, 3);
        checkOutput("t4_after_gnt", m0_gnt_o, 1);
        applyStimulus(0, 0, 0, 1, 33'h6, 0);
        checkOutput("t4_refill", outstd_o, 4);
        applyStimulus(0, 0, 0, 1, 33'h7, 1);
        checkOutput("t4_pushpop", outstd_o, 3);
        checkOutput("t4_m0err", m0_err_o, 1);

        // Stray response with empty FIFO, and a reset with a transaction in flight
        doReset();
        applyStimulus(0, 0, 0, 1, 33'h9, 0);
        checkOutput("t5_rv_drop", {m0_rvalid_o, m1_rvalid_o}, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t5_proto_set", proto_err_o, 1);
        checkOutput("t5_outstd", outstd_o, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t5_proto_sticky", proto_err_o, 1);
        doReset();
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t5_proto_clr", proto_err_o, 0);
        applyStimulus(0, 1, 1, 0, '0, 0);
        doReset();
        applyStimulus(0, 0, 0, 1, 33'hA, 0);
        checkOutput("t5_late_rv", m1_rvalid_o, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t5_late_proto", proto_err_o, 1);

        // Error response routed to m1 only
        doReset();
        applyStimulus(0, 1, 1, 0, '0, 0);
        checkOutput("t6_m1gnt", m1_gnt_o, 1);
        checkOutput("t6_fields", {s_we_o, s_be_o, s_is_cap_o}, {1'b1, 4'h3, 1'b1});
        applyStimulus(0, 0, 0, 1, 33'h0_0BAD_0BAD, 1);
        checkOutput("t6_m1rv_err", {m1_rvalid_o, m1_err_o}, 2'b11);
        checkOutput("t6_m0", {m0_rvalid_o, m0_err_o}, 0);
        checkOutput("t6_m1rd", m1_rdata_o, 33'h0_0BAD_0BAD);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
